uart_rx_fifo_cfg: RTL and testbench
===================================

// Module: uart_rx_fifo_cfg
// PURPOSE
//  Parametrised UART receiver with runtime-configurable baud divisor, parity and
//  stop bits. Validates the start bit and flags parity/framing errors per character.
//  Buffers received characters plus their error tags in a show-ahead FIFO.
//  Sits between the board RX pin and the host-side consumer (SPART/printf bridge).
// PARAMETERS
//  DATA_W      8   data bits per character, legal 5..9, sent LSB first
//  BAUD_W      12  width of baud_div
//  FIFO_DEPTH  4   RX FIFO entries, power of 2, >=2
// PORTS
//  clk        in   1          system clock
//  rst_n      in   1          asynchronous active-low reset
//  RX         in   1          serial input, async, idle high
//  baud_div   in   BAUD_W     bit period = baud_div+1 clks; legal >= 15
//  parity     in   2          00 none, 01 even, 10 odd, 11 = none
//  two_stop   in   1          1: two stop bits checked, 0: one
//  rx_pop     in   1          consume FIFO head when rx_valid
//  clr_ovr    in   1          clear sticky overrun flag
//  rx_valid   out  1          FIFO non-empty
//  rx_data    out  DATA_W     head character (show-ahead)
//  rx_perr    out  1          head character had a parity error
//  rx_ferr    out  1          head character had a framing error
//  overrun    out  1          sticky: a character was dropped because the FIFO was full
//  busy       out  1          FSM not IDLE
// BEHAVIOUR
//  Reset: FIFO empty, rx_valid=0, overrun=0, busy=0, rx_data/rx_perr/rx_ferr=0.
//  Reset: FSM in IDLE, sync flops preset to 1 (no false start out of reset).
//  RX is double-flopped; only the synchronised RX_s is used.
//  Config: baud_div, parity and two_stop are latched on IDLE->START.
//  Config changes mid-character take effect on the next character.
//  Baud counter counts down; a sample is taken when it reaches 0.
//  It reloads with baud_div>>1 on START entry and with baud_div after every sample.
//  FSM states: IDLE, START, DATA, PAR, STOP.
//   IDLE : RX_s==0 -> START (the cycle busy rises).
//   START: mid-bit sample. RX_s==1 -> IDLE (false start, nothing pushed). Else -> DATA.
//   DATA : shift in DATA_W samples LSB first. Then go to PAR if parity enabled, else STOP.
//   PAR  : perr = (XOR of data ^ sample) != (parity==odd). Then go to STOP.
//   STOP : ferr = any sampled stop bit == 0. Samples 1 stop bit, or 2 if two_stop.
//          After the last stop sample, push {perr,ferr,data} and go to IDLE that same cycle.
//  A new start edge is detected from the mid-stop point onwards.
//  Latency: rx_valid rises 1 clk after the last stop sample, when the FIFO was empty.
//  FIFO: push and pop in the same cycle are both performed, even when full.
//  FIFO full, push without pop: the character is dropped and overrun is set.
//   overrun stays set until clr_ovr; on a same-cycle set and clear, set wins.
//  rx_pop while empty is ignored, with no pointer movement.
//  Pointers wrap modulo FIFO_DEPTH; a count register distinguishes full from empty.
//  Reset mid-character aborts the character: FIFO cleared, FSM to IDLE.
// TESTING
//  1. div=433, 8N1, send 0xA5 -> rx_valid 1 clk after stop mid; data=A5, perr=0, ferr=0.
//  2. Even parity, send 0x37 with a wrong parity bit -> data=37, rx_perr=1.
//     Odd parity, send 0x37 with a correct parity bit -> rx_perr=0.
//  3. two_stop=1, send 0x5A with the 2nd stop bit low -> rx_ferr=1, data=5A.
//     Then send a clean 0x00 -> ferr=0.
//  4. RX low for 3 clks only (glitch) -> no push, busy back to 0 after the half-bit.
//     A following 0x81 is received correctly.
//  5. DEPTH=4, send 5 chars with no pop -> first 4 retained in order, 5th dropped, overrun=1.
//     Pop all -> rx_valid=0. clr_ovr -> overrun=0.
//  6. Assert rst_n low mid-DATA -> all outputs at reset values.
//     Next character after reset is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo_cfg.sv
// UART receiver with runtime baud/parity/stop configuration and a show-ahead RX FIFO.
// Each FIFO entry carries the character plus its parity and framing error tags.
module uart_rx_fifo_cfg #(
  parameter int DATA_W     = 8,
  parameter int BAUD_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RX,
  input  logic [BAUD_W-1:0] baud_div,
  input  logic [1:0]        parity,
  input  logic              two_stop,
  input  logic              rx_pop,
  input  logic              clr_ovr,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_perr,
  output logic              rx_ferr,
  output logic              overrun,
  output logic              busy
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = DATA_W + 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t            state, next_state;
  logic              rx_meta, rx_s;
  logic [BAUD_W-1:0] baud_cnt, div_q;
  logic [1:0]        parity_q;
  logic              two_stop_q;
  logic [DATA_W-1:0] shift;
  logic [3:0]        bit_cnt;
  logic              stop_cnt;
  logic              perr, ferr;
  logic              sample, push, last_data, last_stop, par_en, start_go;

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               full, do_pop, do_push;
  logic [ENTRY_W-1:0] head;

  // Preset to idle level so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    push       = 1'b0;
    sample     = (state != IDLE) && (baud_cnt == '0);
    last_data  = (bit_cnt == 4'(DATA_W - 1));
    last_stop  = (stop_cnt == two_stop_q);
    par_en     = (parity_q == 2'b01) || (parity_q == 2'b10);
    case (state)
      IDLE:  if (!rx_s) next_state = START;
      START: if (sample) next_state = rx_s ? IDLE : DATA;
      DATA:  if (sample && last_data) next_state = par_en ? PAR : STOP;
      PAR:   if (sample) next_state = STOP;
      STOP:  if (sample && last_stop) begin
               push       = 1'b1;
               next_state = IDLE;
             end
      default: next_state = IDLE;
    endcase
    start_go = (state == IDLE) && (next_state == START);
  end

  // Config is captured at the start edge so mid-character changes wait a character.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt   <= '0;
      div_q      <= '0;
      parity_q   <= 2'b00;
      two_stop_q <= 1'b0;
      shift      <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
    end else if (start_go) begin
      baud_cnt   <= baud_div >> 1;
      div_q      <= baud_div;
      parity_q   <= parity;
      two_stop_q <= two_stop;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
    end else if (sample) begin
      baud_cnt <= div_q;
      case (state)
        DATA: begin
          shift   <= {rx_s, shift[DATA_W-1:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
        PAR:  perr <= ((^shift) ^ rx_s) != (parity_q == 2'b10);
        STOP: begin
          ferr     <= ferr | ~rx_s;
          stop_cnt <= 1'b1;
        end
        default: ;
      endcase
    end else if (state != IDLE) begin
      baud_cnt <= baud_cnt - 1'b1;
    end
  end

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign do_pop  = rx_pop && (count != '0);
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {perr, ferr | ~rx_s, shift};
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !do_pop) overrun <= 1'b1;
      else if (clr_ovr)            overrun <= 1'b0;
    end
  end

  assign head     = mem[rd_ptr];
  assign rx_valid = (count != '0);
  assign rx_data  = rx_valid ? head[DATA_W-1:0] : '0;
  assign rx_ferr  = rx_valid ? head[DATA_W] : 1'b0;
  assign rx_perr  = rx_valid ? head[DATA_W+1] : 1'b0;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo_cfg.sv
// Directed bench for uart_rx_fifo_cfg: serial frames driven bit by bit,
// FIFO head and flags compared against hand-computed values.
module tb_uart_rx_fifo_cfg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RX;
  logic [11:0] baud_div;
  logic [1:0]  parity;
  logic        two_stop;
  logic        rx_pop;
  logic        clr_ovr;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_perr;
  logic        rx_ferr;
  logic        overrun;
  logic        busy;

  int check_count = 0;
  int pass_count  = 0;
  int bit_clks;

  uart_rx_fifo_cfg #(.DATA_W(8), .BAUD_W(12), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .baud_div(baud_div), .parity(parity),
    .two_stop(two_stop), .rx_pop(rx_pop), .clr_ovr(clr_ovr), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr), .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  task automatic sendBit(input logic b);
    RX = b;
    repeat (bit_clks) @(posedge clk);
    #1;
  endtask

  // Full frame followed by two bit times of idle so the push has landed.
  task automatic applyStimulus(input logic [7:0] d, input logic has_par,
                               input logic par_bit, input logic stop1,
                               input logic has_stop2, input logic stop2);
    @(posedge clk); #1;
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(d[i]);
    if (has_par) sendBit(par_bit);
    sendBit(stop1);
    if (has_stop2) sendBit(stop2);
    sendBit(1'b1);
    sendBit(1'b1);
  endtask

  task automatic popHead();
    rx_pop = 1'b1;
    @(posedge clk); #1;
    rx_pop = 1'b0;
  endtask

  initial begin
    logic [7:0] burst [5];
    burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
    burst[3] = 8'h44; burst[4] = 8'h55;
    RX = 1'b1; baud_div = 12'd433; parity = 2'b00; two_stop = 1'b0;
    rx_pop = 1'b0; clr_ovr = 1'b0; rst_n = 1'b0;
    bit_clks = 434;
    repeat (3) @(posedge clk); #1;
    checkOutput("reset_valid", 16'(rx_valid), 16'h0);
    checkOutput("reset_overrun", 16'(overrun), 16'h0);
    checkOutput("reset_busy", 16'(busy), 16'h0);
    checkOutput("reset_data", 16'(rx_data), 16'h0);
    checkOutput("reset_perr", 16'(rx_perr), 16'h0);
    checkOutput("reset_ferr", 16'(rx_ferr), 16'h0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;

    // 8N1 at div 433: last stop sample lands about 4126 clocks after the fall
    RX = 1'b0;
    repeat (434) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = (8'hA5 >> i) & 1'b1;
      repeat (434) @(posedge clk);
    end
    #1; RX = 1'b1;
    repeat (214) @(posedge clk); #1;
    checkOutput("t1_valid_early", 16'(rx_valid), 16'h0);
    repeat (12) @(posedge clk); #1;
    checkOutput("t1_valid_late", 16'(rx_valid), 16'h1);
    checkOutput("t1_data", 16'(rx_data), 16'hA5);
    checkOutput("t1_perr", 16'(rx_perr), 16'h0);
    checkOutput("t1_ferr", 16'(rx_ferr), 16'h0);
    popHead();
    checkOutput("t1_popped", 16'(rx_valid), 16'h0);
    repeat (500) @(posedge clk); #1;

    baud_div = 12'd15; bit_clks = 16;
    parity = 2'b01;
    applyStimulus(8'h37, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("t2_even_data", 16'(rx_data), 16'h37);
    checkOutput("t2_even_perr", 16'(rx_perr), 16'h1);
    popHead();
    parity = 2'b10;
    applyStimulus(8'h37, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("t2_odd_data", 16'(rx_data), 16'h37);
    checkOutput("t2_odd_perr", 16'(rx_perr), 16'h0);
    checkOutput("t2_odd_ferr", 16'(rx_ferr), 16'h0);
    popHead();

    parity = 2'b00; two_stop = 1'b1;
    applyStimulus(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("t3_bad_ferr", 16'(rx_ferr), 16'h1);
    checkOutput("t3_bad_data", 16'(rx_data), 16'h5A);
    checkOutput("t3_bad_perr", 16'(rx_perr), 16'h0);
    popHead();
    checkOutput("t3_no_false_push", 16'(rx_valid), 16'h0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("t3_clean_valid", 16'(rx_valid), 16'h1);
    checkOutput("t3_clean_ferr", 16'(rx_ferr), 16'h0);
    checkOutput("t3_clean_data", 16'(rx_data), 16'h00);
    popHead();

    two_stop = 1'b0;
    RX = 1'b0;
    repeat (3) @(posedge clk); #1;
    RX = 1'b1;
    repeat (2) @(posedge clk); #1;
    checkOutput("t4_glitch_busy", 16'(busy), 16'h1);
    repeat (20) @(posedge clk); #1;
    checkOutput("t4_glitch_idle", 16'(busy), 16'h0);
    checkOutput("t4_glitch_nopush", 16'(rx_valid), 16'h0);
    applyStimulus(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("t4_after_data", 16'(rx_data), 16'h81);
    popHead();

    for (int i = 0; i < 5; i++) begin
      applyStimulus(burst[i], 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      if (i == 3) checkOutput("t5_full_no_ovr", 16'(overrun), 16'h0);
    end
    checkOutput("t5_overrun", 16'(overrun), 16'h1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t5_order%0d", i), 16'(rx_data), 16'(burst[i]));
      popHead();
    end
    checkOutput("t5_empty", 16'(rx_valid), 16'h0);
    popHead();
    checkOutput("t5_pop_empty", 16'(rx_valid), 16'h0);
    checkOutput("t5_ovr_sticky", 16'(overrun), 16'h1);
    clr_ovr = 1'b1;
    @(posedge clk); #1;
    clr_ovr = 1'b0;
    checkOutput("t5_ovr_clear", 16'(overrun), 16'h0);

    applyStimulus(8'h66, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("t6_pre_valid", 16'(rx_valid), 16'h1);
    @(posedge clk); #1;
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b0);
    checkOutput("t6_mid_busy", 16'(busy), 16'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", 16'(rx_valid), 16'h0);
    checkOutput("t6_rst_busy", 16'(busy), 16'h0);
    checkOutput("t6_rst_data", 16'(rx_data), 16'h0);
    RX = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    applyStimulus(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("t6_after_valid", 16'(rx_valid), 16'h1);
    checkOutput("t6_after_data", 16'(rx_data), 16'hC3);
    popHead();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
